// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory responder: FSM states,
// the NOP returned on faulting fetches and the default reset-vector base.
package imem_pkg;

  localparam logic [31:0] IMEM_NOP       = 32'h00000013;
  localparam logic [31:0] IMEM_BASE_ADDR = 32'hBFC00000;

  // Wide enough for LATENCY-1 with LATENCY up to 4.
  localparam int unsigned IMEM_CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } imem_state_e;

endpackage

// File: rtl/imem_array.sv
// Instruction storage: DEPTH x DATA_WIDTH words, one synchronous write port,
// one combinational read port. Contents are never reset.
//   clk   : clock
//   we    : write enable (caller guarantees waddr is in range)
//   waddr : write word index
//   wdata : write data
//   raddr : read word index
//   rdata : read data (combinational)
module imem_array #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned AW         = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port
  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_responder.sv
// Instruction-fetch responder: accepts one fetch at a time, looks the word up
// at acceptance and presents it LATENCY cycles later, held until consumed.
// Misaligned or out-of-range fetches return NOP with rsp_err set.
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_ready : fetch request handshake (req_ready combinational)
//   req_addr            : fetch byte address
//   rsp_valid/rsp_ready : response handshake
//   rsp_instr, rsp_err  : response word and fault flag
//   load_en/addr/data   : program-loader write port (byte address)
module imem_responder
  import imem_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           DEPTH      = 1024,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = DATA_WIDTH'(IMEM_BASE_ADDR),
  parameter int unsigned           LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] req_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_instr,
  output logic                  rsp_err,
  input  logic                  load_en,
  input  logic [DATA_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data
);

  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = IMEM_CNT_W;
  // Byte span of the array, two extra bits so 4*DEPTH never truncates.
  localparam logic [DATA_WIDTH+1:0] SPAN = (DATA_WIDTH+2)'(DEPTH) << 2;

  imem_state_e            state, state_nx;
  logic [CNT_W-1:0]       cnt, cnt_nx;
  logic [DATA_WIDTH-1:0]  req_off, load_off;
  logic [DATA_WIDTH-1:0]  rd_data;
  logic                   req_ok, load_ok, accept;

  // Offsets wrap modulo 2^DATA_WIDTH, so addresses below the base land far out of range.
  assign req_off  = req_addr - BASE_ADDR;
  assign load_off = load_addr - BASE_ADDR;
  assign req_ok   = (req_addr[1:0] == 2'b00) && ({2'b00, req_off} < SPAN);
  assign load_ok  = (load_addr[1:0] == 2'b00) && ({2'b00, load_off} < SPAN);

  assign req_ready = (state == IDLE) && !load_en;
  assign accept    = req_valid && req_ready;

  imem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_array (
    .clk   (clk),
    .we    (load_en && load_ok),
    .waddr (load_off[AW+1:2]),
    .wdata (load_data),
    .raddr (req_off[AW+1:2]),
    .rdata (rd_data)
  );

  // Next-state and latency counter
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY <= 1) begin
            state_nx = RESP;
          end else begin
            state_nx = WAIT;
            cnt_nx   = CNT_W'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        cnt_nx = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_nx = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, counter and response registers; the word is captured at acceptance
  // so later loader writes cannot disturb an in-flight response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_instr <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      rsp_valid <= (state_nx == RESP);
      if (accept) begin
        rsp_instr <= req_ok ? rd_data : DATA_WIDTH'(IMEM_NOP);
        rsp_err   <= !req_ok;
      end
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: a LATENCY=1 and a LATENCY=3 instance share one
// stimulus stream; a transaction-level model predicts handshake and data.
module tb_imem_responder;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'hBFC00000;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic clk = 1'b0;
  logic rst, req_valid, rsp_ready, load_en;
  logic [31:0] req_addr, load_addr, load_data;
  logic [1:0] o_ready, o_valid, o_err;
  logic [1:0][31:0] o_instr;

  always #5 clk = ~clk;

  imem_responder #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(o_ready[0]), .req_addr(req_addr),
    .rsp_valid(o_valid[0]), .rsp_ready(rsp_ready), .rsp_instr(o_instr[0]), .rsp_err(o_err[0]),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data));

  imem_responder #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(3)) u_dut_l3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(o_ready[1]), .req_addr(req_addr),
    .rsp_valid(o_valid[1]), .rsp_ready(rsp_ready), .rsp_instr(o_instr[1]), .rsp_err(o_err[1]),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data));

  // ---------------- transaction-level model ----------------
  logic [31:0] mdl_mem [int unsigned];
  bit          busy    [2];
  int unsigned acc     [2];
  logic [31:0] m_instr [2];
  bit          m_err   [2];
  bit          m_known [2];
  int unsigned cyc = 0;
  int          m_tests = 0, m_fail = 0;

  function automatic int unsigned lat(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // Response is due from the LATENCY-th cycle after the accepting edge.
  function automatic bit rsp_due(input int i);
    return busy[i] && (cyc + 1 >= acc[i] + lat(i));
  endfunction

  function automatic void lookup(input logic [31:0] a, output logic [31:0] ins,
                                 output bit err, output bit known);
    logic [31:0] off;
    off = a - BASE;
    if (a[1:0] != 2'b00 || off >= 4 * DEPTH) begin
      ins = NOP; err = 1'b1; known = 1'b1;
    end else if (mdl_mem.exists(off >> 2)) begin
      ins = mdl_mem[off >> 2]; err = 1'b0; known = 1'b1;
    end else begin
      ins = 'x; err = 1'b0; known = 1'b0;
    end
  endfunction

  always @(posedge clk) begin
    logic [31:0] loff;
    for (int i = 0; i < 2; i++) begin
      if (rst) busy[i] = 1'b0;
      else if (busy[i]) begin
        if (rsp_due(i) && rsp_ready) busy[i] = 1'b0;
      end else if (req_valid && !load_en) begin
        lookup(req_addr, m_instr[i], m_err[i], m_known[i]);
        busy[i] = 1'b1;
        acc[i]  = cyc + 1;
      end
    end
    loff = load_addr - BASE;
    if (load_en && load_addr[1:0] == 2'b00 && loff < 4 * DEPTH) mdl_mem[loff >> 2] = load_data;
    cyc = cyc + 1;
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    bit exp_ready, exp_valid;
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        exp_ready = !busy[i] && !load_en;
        exp_valid = rsp_due(i);
        m_tests++;
        if (o_ready[i] !== exp_ready) begin
          m_fail++;
          $display("FAIL mdl_req_ready[L%0d] cyc %0d: got %b expected %b", lat(i), cyc, o_ready[i], exp_ready);
        end
        m_tests++;
        if (o_valid[i] !== exp_valid) begin
          m_fail++;
          $display("FAIL mdl_rsp_valid[L%0d] cyc %0d: got %b expected %b", lat(i), cyc, o_valid[i], exp_valid);
        end
        if (exp_valid && m_known[i]) begin
          m_tests++;
          if (o_instr[i] !== m_instr[i] || o_err[i] !== m_err[i]) begin
            m_fail++;
            $display("FAIL mdl_rsp_data[L%0d] cyc %0d: got %h/%b expected %h/%b",
                     lat(i), cyc, o_instr[i], o_err[i], m_instr[i], m_err[i]);
          end
        end
      end
    end
  end

  // ---------------- directed stimulus and literal checks ----------------
  int n_tests = 0, n_fail = 0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic pulse_req(input logic [31:0] a);
    req_valid = 1'b1; req_addr = a;
    tick();
    req_valid = 1'b0;
  endtask

  // Waits (bounded) for the LATENCY=3 instance to respond, then checks it.
  task automatic check_v3(input string name, input logic [31:0] ei, input logic ee);
    bit seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (o_valid[1] === 1'b1) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (seen) begin
      chk({name, "_instr"}, o_instr[1], ei);
      chk({name, "_err"}, 32'(o_err[1]), 32'(ee));
    end else begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: got no rsp_valid expected rsp_valid within 10 cycles", name);
    end
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (!busy[0] && !busy[1]) begin done = 1'b1; break; end
      tick();
    end
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL idle_timeout: got busy expected idle within 20 cycles");
    end
  endtask

  task automatic req_check(input string name, input logic [31:0] a,
                           input logic [31:0] ei, input logic ee);
    pulse_req(a);
    check_v3(name, ei, ee);
    wait_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500us");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1; load_en = 1'b0;
    req_addr = '0; load_addr = '0; load_data = '0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_ready", 32'(o_ready[i]), 32'd1);
      chk("reset_valid", 32'(o_valid[i]), 32'd0);
      chk("reset_instr", o_instr[i], 32'h0);
      chk("reset_err", 32'(o_err[i]), 32'd0);
    end
    tick();

    // Program image; the last two writes are out of range / misaligned and must be dropped.
    load(32'hBFC00000, 32'h00500093);
    load(32'hBFC00004, 32'h00100113);
    load(32'hBFC00014, 32'h0AA00513);
    load(32'hBFC00FFC, 32'h12345678);
    load(32'hBFC01000, 32'hDEADBEEF);
    load(32'hBFC00006, 32'hDEADBEEF);

    // Single-cycle latency fetch of word 0
    pulse_req(32'hBFC00000);
    @(negedge clk);
    chk("l1_valid", 32'(o_valid[0]), 32'd1);
    chk("l1_instr", o_instr[0], 32'h00500093);
    chk("l1_err", 32'(o_err[0]), 32'd0);
    chk("l3_not_yet", 32'(o_valid[1]), 32'd0);
    wait_idle();

    req_check("word1", 32'hBFC00004, 32'h00100113, 1'b0);
    req_check("last_word", 32'hBFC00FFC, 32'h12345678, 1'b0);
    req_check("misaligned", 32'hBFC00002, NOP, 1'b1);
    req_check("misaligned6", 32'hBFC00006, NOP, 1'b1);
    req_check("past_end", 32'hBFC01000, NOP, 1'b1);
    req_check("below_base", 32'hBFBFFFFC, NOP, 1'b1);

    // Latency-3 timing with back-pressure until the third responding cycle
    rsp_ready = 1'b0;
    pulse_req(32'hBFC00004);
    @(negedge clk); chk("t11_valid", 32'(o_valid[1]), 32'd0);
    tick(); @(negedge clk); chk("t12_valid", 32'(o_valid[1]), 32'd0);
    tick(); @(negedge clk); chk("t13_valid", 32'(o_valid[1]), 32'd1);
    chk("t13_instr", o_instr[1], 32'h00100113);
    tick(); @(negedge clk); chk("t14_instr", o_instr[1], 32'h00100113);
    tick(); rsp_ready = 1'b1;
    @(negedge clk); chk("t15_valid", 32'(o_valid[1]), 32'd1);
    chk("t15_instr", o_instr[1], 32'h00100113);
    tick(); @(negedge clk);
    chk("t16_ready", 32'(o_ready[1]), 32'd1);
    chk("t16_valid", 32'(o_valid[1]), 32'd0);
    wait_idle();

    // Write to an in-flight word must not change the held response
    pulse_req(32'hBFC00014);
    load(32'hBFC00014, 32'h0BB00513);
    check_v3("old_word5", 32'h0AA00513, 1'b0);
    wait_idle();
    req_check("new_word5", 32'hBFC00014, 32'h0BB00513, 1'b0);

    // Load collides with request: write wins, request waits a cycle
    load_en = 1'b1; load_addr = 32'hBFC0001C; load_data = 32'h00700393;
    req_valid = 1'b1; req_addr = 32'hBFC0001C;
    @(negedge clk);
    chk("collide_ready_l1", 32'(o_ready[0]), 32'd0);
    chk("collide_ready_l3", 32'(o_ready[1]), 32'd0);
    tick();
    load_en = 1'b0;
    @(negedge clk);
    chk("after_load_ready", 32'(o_ready[1]), 32'd1);
    tick();
    req_valid = 1'b0;
    check_v3("collide_word7", 32'h00700393, 1'b0);
    wait_idle();

    // Reset while the latency-3 instance is waiting
    pulse_req(32'hBFC00000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_mid_ready", 32'(o_ready[i]), 32'd1);
      chk("rst_mid_valid", 32'(o_valid[i]), 32'd0);
      chk("rst_mid_instr", o_instr[i], 32'h0);
      chk("rst_mid_err", 32'(o_err[i]), 32'd0);
    end
    for (int k = 0; k < 4; k++) begin
      tick(); @(negedge clk);
      chk("rst_no_rsp", 32'(o_valid[1]), 32'd0);
    end
    wait_idle();

    n_tests += m_tests;
    n_fail  += m_fail;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameter DATA_WIDTH SHALL be provided, default 32, giving the instruction and address width.
REQ-002 Parameter DEPTH SHALL be provided, default 1024, giving the number of instruction words held.
REQ-003 Parameter BASE_ADDR SHALL be provided, default 32'hBFC00000, giving the byte address of word 0.
REQ-004 Parameter LATENCY SHALL be provided, default 1, legal range 1..4, giving the accept-to-response cycle count.
REQ-005 Port clk SHALL be an input, 1 bit, the single clock; one clock; reset is synchronous and active-high.
REQ-006 Port rst SHALL be an input, 1 bit, synchronous active-high reset.
REQ-007 Port req_valid SHALL be an input, 1 bit, meaning the fetch request is valid.
REQ-008 Port req_ready SHALL be an output, 1 bit, meaning the responder accepts a request this cycle.
REQ-009 Port req_addr SHALL be an input, DATA_WIDTH bits, giving the fetch byte address (the PC).
REQ-010 Port rsp_valid SHALL be an output, 1 bit, meaning the response is valid.
REQ-011 Port rsp_ready SHALL be an input, 1 bit, meaning the fetch side consumes the response.
REQ-012 Port rsp_instr SHALL be an output, DATA_WIDTH bits, carrying the instruction word.
REQ-013 Port rsp_err SHALL be an output, 1 bit, flagging a misaligned or out-of-range fetch.
REQ-014 Ports load_en (input, 1 bit), load_addr (input, DATA_WIDTH bits, byte address) and load_data (input, DATA_WIDTH bits) SHALL form the program-loader write port.

Function
REQ-015 FSM states SHALL be IDLE, WAIT and RESP.
REQ-016 req_ready SHALL equal (state==IDLE) && !load_en, and SHALL be combinational.
REQ-017 A request SHALL be accepted on a rising edge where req_valid && req_ready; the array word SHALL be read and the error status computed at acceptance and held in a response register.
REQ-018 On acceptance, a LATENCY of 1 SHALL move the FSM to RESP; otherwise it SHALL move to WAIT with the counter loaded to LATENCY-1.
REQ-019 WAIT SHALL decrement the counter each cycle and move to RESP when the counter reaches 1, so rsp_valid rises exactly LATENCY cycles after the accept edge.
REQ-020 In RESP, rsp_valid SHALL be 1 and rsp_instr/rsp_err SHALL be held stable until a cycle with rsp_ready=1, after which the FSM SHALL return to IDLE.
REQ-021 Back-to-back requests SHALL NOT overlap; minimum request spacing SHALL be LATENCY+1 cycles.
REQ-022 Word index SHALL be (req_addr - BASE_ADDR) >> 2, computed modulo 2^DATA_WIDTH.
REQ-023 If req_addr[1:0] != 0, or the offset (req_addr - BASE_ADDR) >= 4*DEPTH (including wrap-around below BASE_ADDR), rsp_err SHALL be 1 and rsp_instr SHALL be NOP 32'h00000013 after the normal latency.
REQ-024 When load_en=1 and load_addr is aligned and in range, load_data SHALL be written into the array on that edge; other load addresses SHALL be ignored.
REQ-025 Writes SHALL be accepted in every state; a write to the word of an in-flight request SHALL NOT alter its held response.
REQ-026 A simultaneous load_en and req_valid in IDLE SHALL perform the write and SHALL NOT accept the request (req_ready=0).
REQ-027 Array contents SHALL be unspecified until loaded.

Reset
REQ-028 rst SHALL synchronously force state=IDLE, counter=0, rsp_valid=0, rsp_instr=0 and rsp_err=0, with req_ready=1 on the following cycle when load_en=0.
REQ-029 Reset mid-operation (WAIT or RESP) SHALL discard the in-flight response without ever asserting rsp_valid for it.
REQ-030 Array contents SHALL NOT be reset.

Structure
REQ-031 A shared package imem_pkg SHALL hold the state enum, the NOP constant 32'h00000013 and the default BASE_ADDR 32'hBFC00000.
REQ-032 Storage SHALL be one sub-module, imem_array: a DEPTH x DATA_WIDTH array with one synchronous write port and one combinational read port.

Verification
REQ-033 Load 32'h00500093 at 32'hBFC00000, LATENCY=1, request 32'hBFC00000 -> rsp_valid next cycle, rsp_instr=32'h00500093, rsp_err=0.
REQ-034 LATENCY=3, request accepted at cycle 10 with rsp_ready held 0 until cycle 15 -> rsp_valid rises at cycle 13, data stable through 15, req_ready=1 at cycle 16.
REQ-035 Request 32'hBFC00002 -> rsp_err=1, rsp_instr=32'h00000013; request 32'hBFC01000 (DEPTH=1024) -> rsp_err=1; request 32'hBFBFFFFC -> rsp_err=1.
REQ-036 Request word 5, then during WAIT load new data to word 5 -> response carries the old value; a following request returns the new value.
REQ-037 load_en and req_valid both high in IDLE -> write occurs, req_ready=0, request accepted the next cycle after load_en drops.
REQ-038 Assert rst during WAIT -> rsp_valid never rises for that request, all outputs are 0 and req_ready=1 one cycle after rst falls.
